regfile_sequencer: RTL and testbench
====================================

# regfile_sequencer

Micro-sequencer that drives the 4-entry register file's two read selects and single write port to execute one register-level operation per `start` handshake.
- Operations: load-immediate, add, subtract and AND.
- Sits between the control logic issuing operations and the register file, and owns all register file control signals.
- Captures operands, computes in a built-in ALU, writes back, then signals `done`.

## Interface
Parameters:
- `W`, default 4: data width; must equal register file data width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: operation request, sampled only in IDLE.
- `op` in 2: 00 LDI, 01 ADD, 10 SUB, 11 AND.
- `ra`, `rb` in 2: source register indices.
- `rd` in 2: destination register index.
- `imm` in W: immediate for LDI.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `result` out W: last value written back.
- `zf`, `cf` out 1: zero flag, carry/borrow flag of last operation.
- `rs`, `rt` out 2: register file read selects.
- `crs`, `crt` in W: register file read data.
- `rw` out 2: register file write select.
- `dw` out W: register file write data.
- `rwe` out 1: register file write enable.

## Operation
- All outputs registered. Reset value of every output is 0; FSM resets to IDLE.
- States: IDLE, PRIME, READ, EXEC, WRITE, DONE.
- **IDLE**, `start`=1: latch `op`, `ra`, `rb`, `rd`, `imm`.
  - LDI goes to WRITE.
  - All other ops go to PRIME.
  - `start`=0: stay in IDLE.
- **PRIME**: drive `rs`=~ra, `rt`=~rb (bitwise invert of latched indices).
  - The register file read mux re-evaluates only on a select change; PRIME guarantees a transition before every read.
- **READ**: drive `rs`=ra, `rt`=rb. Selects stay stable through EXEC.
- **EXEC**: capture `crs`/`crt`, compute, update `result`/`zf`/`cf`.
  - ADD: {cf,res} = crs + crt. Sum is W+1 bits; res wraps mod 2^W.
  - SUB: res = crs - crt mod 2^W; cf = 1 iff crs < crt (unsigned borrow).
  - AND: res = crs & crt; cf = 0.
  - zf = (res == 0).
- **WRITE**: `rwe`=1, `rw`=rd, `dw`=res. Register file commits on the edge ending WRITE.
  - For LDI: res = imm, cf = 0, zf = (imm == 0); `result`/flags update on entry to WRITE.
- **DONE**: `done`=1, `rwe`=0, then go to IDLE.
- `start` asserted outside IDLE is ignored, not queued.
- `rwe` is high for exactly one cycle per operation and never outside WRITE.
- Latched operands are immune to input changes after acceptance.
- `ra`==`rb`, and `rd` equal to a source, are both legal. Sources are read before write-back.
- Outside PRIME/READ/EXEC, `rs`/`rt` hold their last value. `rw`/`dw` hold their last value when `rwe`=0.

## Timing
- Edge E0: `start` sampled high in IDLE.
- ALU op timeline:
  - PRIME in cycle E0..E1.
  - READ E1..E2.
  - EXEC E2..E3.
  - WRITE E3..E4; register updated at E4.
  - `done` high E4..E5.
  - IDLE from E5.
- ALU op totals: `busy` high 5 cycles; `result` valid from E3.
- LDI timeline:
  - WRITE E0..E1; register updated at E1.
  - `done` high E1..E2.
  - IDLE from E2.
- `start` held high: the next op is accepted at the edge leaving the first IDLE cycle after DONE. Minimum one IDLE cycle between operations.
- `rst` assertion at any point:
  - Outputs go to reset values immediately, including `rwe`=0 mid-WRITE, so no write commits unless the write edge precedes `rst`.
  - State returns to IDLE; the operation is dropped with no `done`.
- `rst` release: first `start` is sampled at the first rising edge with `rst` low.

## Test plan
- Reset, then LDI rd=1 imm=9 -> `rwe`=1 for one cycle with `rw`=01, `dw`=9; `done` one cycle later; `zf`=0, `cf`=0; total latency 2 cycles.
- LDI r2=7, then ADD ra=1 rb=2 rd=0 (9+7) -> `result`=0, `zf`=1, `cf`=1. Then ADD ra=0 rb=0 rd=0 -> reads the fresh 0 via PRIME; `result`=0.
- SUB ra=2 rb=1 (7-9) -> `result`=E, `cf`=1. SUB ra=1 rb=2 (9-7) -> `result`=2, `cf`=0, `zf`=0.
- AND ra=1 rb=1 rd=3 -> `result`=9, `cf`=0. Pulse `start` while `busy` -> ignored; exactly one `rwe` pulse and one `done`.
- `start` held high over three LDIs -> three `done` pulses, each separated by exactly one IDLE cycle; `busy` drops for one cycle between them.
- Preload r0=5. ADD rd=0 with `rst` pulsed during EXEC -> `rwe` never asserted, no `done`, all outputs 0. After reset, AND ra=0 rb=0 still returns 5.

Source files
------------

// File: rtl/regfile_sequencer_if.sv
// regfile_sequencer_if: operation request/response and register file port bundle.
// The slave modport is the sequencer's view; master is the controller plus register file.
interface regfile_sequencer_if #(parameter int W = 4);
    logic         start;
    logic [1:0]   op;
    logic [1:0]   ra;
    logic [1:0]   rb;
    logic [1:0]   rd;
    logic [W-1:0] imm;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zf;
    logic         cf;
    logic [1:0]   rs;
    logic [1:0]   rt;
    logic [W-1:0] crs;
    logic [W-1:0] crt;
    logic [1:0]   rw;
    logic [W-1:0] dw;
    logic         rwe;
    modport master (
        output start, op, ra, rb, rd, imm, crs, crt,
        input  busy, done, result, zf, cf, rs, rt, rw, dw, rwe
    );
    modport slave (
        input  start, op, ra, rb, rd, imm, crs, crt,
        output busy, done, result, zf, cf, rs, rt, rw, dw, rwe
    );
endinterface

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: runs one LDI/ADD/SUB/AND per start handshake against a 4-entry register file.
// Every output is registered; the FSM computes next values, one register stage commits them.
module regfile_sequencer #(parameter int W = 4) (
    input logic clk,
    input logic rst,
    regfile_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PRIME, READ, EXEC, WRITE, DONE} state_t;
    state_t state, next;
    logic [1:0] op_q, ra_q, rb_q, rd_q;
    logic [W:0] sum, diff;
    logic [W-1:0] alu_res;
    logic alu_cf;
    logic [1:0] n_rs, n_rt, n_rw;
    logic [W-1:0] n_dw, n_result;
    logic n_rwe, n_done, n_zf, n_cf;

    assign sum = {1'b0, bus.crs} + {1'b0, bus.crt};
    assign diff = {1'b0, bus.crs} - {1'b0, bus.crt};
    assign alu_res = op_q == 2'b01 ? sum[W-1:0] : op_q == 2'b10 ? diff[W-1:0] : bus.crs & bus.crt;
    assign alu_cf = op_q == 2'b01 ? sum[W] : op_q == 2'b10 ? diff[W] : 1'b0;

    always_comb begin
        next = state;
        n_rs = bus.rs;
        n_rt = bus.rt;
        n_rw = bus.rw;
        n_dw = bus.dw;
        n_rwe = 1'b0;
        n_done = 1'b0;
        n_result = bus.result;
        n_zf = bus.zf;
        n_cf = bus.cf;
        case (state)
            IDLE: if (bus.start) begin
                if (bus.op == 2'b00) begin
                    next = WRITE;
                    n_result = bus.imm;
                    n_zf = bus.imm == '0;
                    n_cf = 1'b0;
                    n_rwe = 1'b1;
                    n_rw = bus.rd;
                    n_dw = bus.imm;
                end else begin
                    // inverted selects force a read-mux transition before the real read
                    next = PRIME;
                    n_rs = ~bus.ra;
                    n_rt = ~bus.rb;
                end
            end
            PRIME: begin
                next = READ;
                n_rs = ra_q;
                n_rt = rb_q;
            end
            READ: next = EXEC;
            EXEC: begin
                next = WRITE;
                n_result = alu_res;
                n_zf = alu_res == '0;
                n_cf = alu_cf;
                n_rwe = 1'b1;
                n_rw = rd_q;
                n_dw = alu_res;
            end
            WRITE: begin
                next = DONE;
                n_done = 1'b1;
            end
            DONE: next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            {op_q, ra_q, rb_q, rd_q} <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.result <= '0;
            bus.zf <= 1'b0;
            bus.cf <= 1'b0;
            bus.rs <= '0;
            bus.rt <= '0;
            bus.rw <= '0;
            bus.dw <= '0;
            bus.rwe <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && bus.start) {op_q, ra_q, rb_q, rd_q} <= {bus.op, bus.ra, bus.rb, bus.rd};
            bus.busy <= next != IDLE;
            bus.done <= n_done;
            bus.result <= n_result;
            bus.zf <= n_zf;
            bus.cf <= n_cf;
            bus.rs <= n_rs;
            bus.rt <= n_rt;
            bus.rw <= n_rw;
            bus.dw <= n_dw;
            bus.rwe <= n_rwe;
        end
    end
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: directed plan plus random operations against an architectural register model.
// The local register file only refreshes read data on a select change, like the real one.
module tb_regfile_sequencer;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [W-1:0] regs [4];
    logic [W-1:0] mregs [4];

    always #5 clk = ~clk;

    regfile_sequencer_if #(.W(W)) bus();
    regfile_sequencer #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always @(posedge clk) if (bus.rwe) regs[bus.rw] <= bus.dw;
    always @(bus.rs) bus.crs = regs[bus.rs];
    always @(bus.rt) bus.crt = regs[bus.rt];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [1:0] a, input logic [1:0] b,
                          input logic [1:0] d, input logic [W-1:0] im);
        logic [W:0] x, y;
        logic [W-1:0] res, dw_s;
        logic [1:0] rw_s;
        logic c;
        int lat, rwe_n, rwe_t, done_n, done_t, busy_n;
        x = {1'b0, mregs[a]};
        y = {1'b0, mregs[b]};
        case (o)
            2'd0: begin res = im; c = 1'b0; end
            2'd1: {c, res} = x + y;
            2'd2: begin res = W'(x - y); c = x < y; end
            default: begin res = x[W-1:0] & y[W-1:0]; c = 1'b0; end
        endcase
        lat = o == 2'd0 ? 0 : 3;
        {rwe_n, rwe_t, done_n, done_t, busy_n} = {5{-1}};
        {rwe_n, done_n, busy_n} = '0;
        rw_s = '0;
        dw_s = '0;
        @(negedge clk);
        {bus.start, bus.op, bus.ra, bus.rb, bus.rd, bus.imm} = {1'b1, o, a, b, d, im};
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (bus.rwe) begin rwe_n++; rwe_t = t; rw_s = bus.rw; dw_s = bus.dw; end
            if (bus.done) begin done_n++; done_t = t; end
            if (bus.busy) busy_n++;
            // stray requests and operand churn while busy must change nothing
            bus.start = bus.busy & 1'($urandom_range(0, 1));
            {bus.op, bus.ra, bus.rb, bus.rd, bus.imm} = (8 + W)'($urandom);
        end
        bus.start = 1'b0;
        chk("rwe_count", rwe_n, 1);
        chk("rwe_cycle", rwe_t, lat);
        chk("rw", rw_s, d);
        chk("dw", dw_s, res);
        chk("done_count", done_n, 1);
        chk("done_cycle", done_t, lat + 1);
        chk("busy_cycles", busy_n, lat + 2);
        chk("result", bus.result, res);
        chk("zf", bus.zf, res == '0);
        chk("cf", bus.cf, c);
        mregs[d] = res;
    endtask

    task automatic run_hold(input logic [W-1:0] im);
        int done_t[$];
        int rwe_n, low_n, dw_bad;
        {rwe_n, low_n, dw_bad} = '0;
        @(negedge clk);
        {bus.start, bus.op, bus.rd, bus.imm} = {1'b1, 2'd0, 2'd3, im};
        for (int t = 0; t < 9; t++) begin
            @(negedge clk);
            if (bus.rwe) begin
                rwe_n++;
                if (bus.dw !== im || bus.rw !== 2'd3) dw_bad++;
            end
            if (bus.done) done_t.push_back(t);
            if (t < 8 && !bus.busy) low_n++;
            if (t == 7) bus.start = 1'b0;
        end
        chk("hold_rwe_count", rwe_n, 3);
        chk("hold_write_data", dw_bad, 0);
        chk("hold_done_count", done_t.size(), 3);
        if (done_t.size() == 3) begin
            chk("hold_gap1", done_t[1] - done_t[0], 3);
            chk("hold_gap2", done_t[2] - done_t[1], 3);
        end
        chk("hold_idle_cycles", low_n, 2);
        mregs[3] = im;
    endtask

    task automatic run_reset_mid_exec();
        int rwe_n, done_n;
        {rwe_n, done_n} = '0;
        @(negedge clk);
        {bus.start, bus.op, bus.ra, bus.rb, bus.rd} = {1'b1, 2'd1, 2'd0, 2'd0, 2'd0};
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.rwe) rwe_n++;
            if (bus.done) done_n++;
            if (t == 2) begin
                rst = 1'b1;
                #1;
                chk("rst_outputs", {bus.busy, bus.done, bus.result, bus.zf, bus.cf, bus.rs, bus.rt,
                                    bus.rw, bus.dw, bus.rwe}, 0);
            end
            if (t == 3) rst = 1'b0;
        end
        chk("rst_rwe_count", rwe_n, 0);
        chk("rst_done_count", done_n, 0);
    endtask

    initial begin
        {bus.start, bus.op, bus.ra, bus.rb, bus.rd, bus.imm} = '0;
        for (int i = 0; i < 4; i++) begin regs[i] = '0; mregs[i] = '0; end
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.busy, bus.done, bus.result, bus.zf, bus.cf, bus.rs, bus.rt,
                              bus.rw, bus.dw, bus.rwe}, 0);
        rst = 1'b0;
        run_op(2'd0, 2'd0, 2'd0, 2'd1, 4'd9);
        run_op(2'd0, 2'd0, 2'd0, 2'd2, 4'd7);
        run_op(2'd1, 2'd1, 2'd2, 2'd0, 4'd0);
        run_op(2'd1, 2'd0, 2'd0, 2'd0, 4'd0);
        run_op(2'd2, 2'd2, 2'd1, 2'd3, 4'd0);
        run_op(2'd2, 2'd1, 2'd2, 2'd3, 4'd0);
        run_op(2'd3, 2'd1, 2'd1, 2'd3, 4'd0);
        run_hold(4'd6);
        run_op(2'd0, 2'd0, 2'd0, 2'd0, 4'd5);
        run_reset_mid_exec();
        run_op(2'd3, 2'd0, 2'd0, 2'd2, 4'd0);
        for (int i = 0; i < 40; i++)
            run_op(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), W'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
